target_stepper: RTL

Game-step sequencer directly downstream of the speed-interval counter. It consumes the counter's one-cycle `timeout` pulses and drives the counter's `enable` and `speed` inputs. On each timeout it advances a pseudo-random target LED and scores debounced player presses against it. It also raises the speed level as the score grows and ends the game after too many misses.

---
 rtl/target_stepper.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/target_stepper.sv
// Game-step sequencer: picks LFSR targets on each timeout and scores presses.
// Optional macro WRONG_PRESS_PENALTY_EN makes wrong presses count as misses.
module target_stepper #(
  parameter logic [7:0] SEED     = 8'hA5,
  parameter int         LEVEL2   = 8,
  parameter int         LEVEL3   = 16,
  parameter int         MAX_MISS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       timeout,
  input  logic [3:0] button,
  output logic       enable,
  output logic [1:0] speed,
  output logic [3:0] led,
  output logic [7:0] score,
  output logic       game_over
);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  localparam logic [7:0] LV2 = 8'(LEVEL2);
  localparam logic [7:0] LV3 = 8'(LEVEL3);
  localparam logic [3:0] MM  = 4'(MAX_MISS);

  state_t     state, state_n;
  logic [3:0] miss, miss_n;
  logic       armed, armed_n;
  logic [7:0] lfsr, lfsr_n;
  logic [1:0] idx, idx_n;
  logic       enable_n, game_over_n;
  logic [1:0] speed_n;
  logic [3:0] led_n;
  logic [7:0] score_n;

  logic [7:0] lfsr_step;
  logic [1:0] p, p_adj;
  logic       hit, wrong, pen_miss, miss_inc, init;
  logic [3:0] miss_sum;
  logic [7:0] score_up;

  // State and output registers; reset wins over every input
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      enable    <= 1'b0;
      speed     <= 2'd0;
      led       <= 4'd0;
      score     <= 8'd0;
      game_over <= 1'b0;
      miss      <= 4'd0;
      armed     <= 1'b0;
      lfsr      <= SEED;
      idx       <= 2'd0;
    end else begin
      state     <= state_n;
      enable    <= enable_n;
      speed     <= speed_n;
      led       <= led_n;
      score     <= score_n;
      game_over <= game_over_n;
      miss      <= miss_n;
      armed     <= armed_n;
      lfsr      <= lfsr_n;
      idx       <= idx_n;
    end
  end

  // Next-state: press judging, miss counting, target stepping, speed level
  always_comb begin
    state_n     = state;
    enable_n    = enable;
    speed_n     = speed;
    led_n       = led;
    score_n     = score;
    game_over_n = game_over;
    miss_n      = miss;
    armed_n     = armed;
    lfsr_n      = lfsr;
    idx_n       = idx;
    init        = 1'b0;

    lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    p         = lfsr_step[1:0];
    p_adj     = (p == idx) ? p + 2'd1 : p;

    hit   = armed && (button == led);
    wrong = armed && (button != 4'd0) && (button != led);
`ifdef WRONG_PRESS_PENALTY_EN
    pen_miss = wrong;
`else
    pen_miss = 1'b0;
`endif
    miss_inc = (timeout && armed && !hit) || pen_miss;
    miss_sum = miss + {3'd0, miss_inc};
    score_up = (hit && score != 8'hFF) ? score + 8'd1 : score;

    unique case (state)
      IDLE: if (start) init = 1'b1;
      RUN: begin
        if (miss_sum == MM) begin
          state_n     = OVER;
          miss_n      = miss_sum;
          enable_n    = 1'b0;
          led_n       = 4'b1111;
          game_over_n = 1'b1;
          armed_n     = 1'b0;
        end else begin
          miss_n  = miss_sum;
          score_n = score_up;
          if (score_up >= LV3)      speed_n = 2'd2;
          else if (score_up >= LV2) speed_n = 2'd1;
          else                      speed_n = 2'd0;
          if (hit) begin
            armed_n = 1'b0;
            led_n   = 4'd0;
          end
          if (pen_miss) armed_n = 1'b0;
          if (timeout) begin
            lfsr_n  = lfsr_step;
            idx_n   = p_adj;
            led_n   = 4'b0001 << p_adj;
            armed_n = 1'b1;
          end
        end
      end
      OVER: if (start) init = 1'b1;
      default: state_n = IDLE;
    endcase

    if (init) begin
      state_n     = RUN;
      score_n     = 8'd0;
      miss_n      = 4'd0;
      speed_n     = 2'd0;
      lfsr_n      = SEED;
      idx_n       = SEED[1:0];
      led_n       = 4'b0001 << SEED[1:0];
      armed_n     = 1'b1;
      enable_n    = 1'b1;
      game_over_n = 1'b0;
    end
  end

endmodule
